// File: rtl/ibex_mem_arb_ram.sv
// Multi-port word memory speaking the Ibex req/gnt/rvalid protocol.
// Ports share one array through a round-robin arbiter (one access per cycle).
// Responses return through a fixed-latency pipeline, in grant order.
// Out-of-range accesses produce err=1 and never touch the array.
// Depth is assumed to be a power of two and at least 2.

module ibex_mem_arb_ram #(
   parameter int unsigned NumPorts = 2,
   parameter int unsigned Depth    = 16384,
   parameter int unsigned Latency  = 1,
   parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumPorts-1:0]      req_i,
   input  logic [NumPorts-1:0]      we_i,
   input  logic [NumPorts*4-1:0]    be_i,
   input  logic [NumPorts*32-1:0]   addr_i,
   input  logic [NumPorts*32-1:0]   wdata_i,
   input  logic [NumPorts-1:0]      gnt_block_i,
   output logic [NumPorts-1:0]      gnt_o,
   output logic [NumPorts-1:0]      rvalid_o,
   output logic [NumPorts*32-1:0]   rdata_o,
   output logic [NumPorts-1:0]      err_o
);

   localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned IdxW = $clog2(Depth);

   // Arbitration state
   logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
   logic [NumPorts-1:0] eligible;
   logic            gnt_any;
   logic [PtrW-1:0] gnt_idx;

   // Granted-port request fields
   logic        sel_we;
   logic [3:0]  sel_be;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   // Address decode
   logic [31:0]     offset;
   logic            in_range;
   logic [IdxW-1:0] widx;
   logic            unused_offset;

   // Stage-0 response and memory write strobe
   logic        mem_we;
   logic [31:0] s0_rdata;
   logic        s0_err;

   // Storage: contents are deliberately not reset
   logic [31:0] mem_q [Depth];

   // Response pipeline, index Latency-1 is the output stage
   logic [Latency-1:0] pv_q;
   logic [Latency-1:0] perr_q;
   logic [PtrW-1:0]    pid_q [Latency];
   logic [31:0]        prd_q [Latency];

   assign eligible = req_i & ~gnt_block_i;

   // Round-robin pick: first eligible port at or above rr_ptr, then wrap to the low ports
   always_comb begin
      gnt_o   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (!rst_i) begin
         for (int p = 0; p < NumPorts; p++) begin
            if (!gnt_any && eligible[p] && (p >= int'(rr_ptr_q))) begin
               gnt_any  = 1'b1;
               gnt_idx  = PtrW'(p);
               gnt_o[p] = 1'b1;
            end
         end
         for (int p = 0; p < NumPorts; p++) begin
            if (!gnt_any && eligible[p] && (p < int'(rr_ptr_q))) begin
               gnt_any  = 1'b1;
               gnt_idx  = PtrW'(p);
               gnt_o[p] = 1'b1;
            end
         end
      end
   end

   // Pointer moves just past the winner; holds when nothing is granted
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_any) begin
         if (gnt_idx == PtrW'(NumPorts - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx + 1'b1;
         end
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Mux the granted port's request fields (gnt_o is one-hot or zero)
   always_comb begin
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (gnt_o[p]) begin
            sel_we    = we_i[p];
            sel_be    = be_i[4*p +: 4];
            sel_addr  = addr_i[32*p +: 32];
            sel_wdata = wdata_i[32*p +: 32];
         end
      end
   end

   // Offset wraps at 32 bits, so addresses below BaseAddr land far out of range
   assign offset        = sel_addr - BaseAddr;
   assign in_range      = (offset[31:IdxW+2] == '0);
   assign widx          = offset[IdxW+1:2];
   assign unused_offset = ^offset[1:0];

   // Stage-0 contents; reads see the array before this edge's write
   always_comb begin
      mem_we   = gnt_any & sel_we & in_range;
      s0_err   = gnt_any & ~in_range;
      s0_rdata = '0;
      if (gnt_any && !sel_we && in_range) begin
         s0_rdata = mem_q[widx];
      end
   end

   // Byte-lane writes into the shared array
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_be[b]) begin
               mem_q[widx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
         end
      end
   end

   // Response shift register; reset drops anything in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pv_q   <= '0;
         perr_q <= '0;
         for (int i = 0; i < Latency; i++) begin
            pid_q[i] <= '0;
            prd_q[i] <= '0;
         end
      end else begin
         pv_q[0]   <= gnt_any;
         perr_q[0] <= s0_err;
         pid_q[0]  <= gnt_idx;
         prd_q[0]  <= s0_rdata;
         for (int i = 1; i < Latency; i++) begin
            pv_q[i]   <= pv_q[i-1];
            perr_q[i] <= perr_q[i-1];
            pid_q[i]  <= pid_q[i-1];
            prd_q[i]  <= prd_q[i-1];
         end
      end
   end

   // Steer the output stage onto its port's lanes; all other lanes stay zero
   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      err_o    = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (pv_q[Latency-1] && (pid_q[Latency-1] == PtrW'(p))) begin
            rvalid_o[p]         = 1'b1;
            rdata_o[32*p +: 32] = prd_q[Latency-1];
            err_o[p]            = perr_q[Latency-1];
         end
      end
   end

endmodule
